loop_stack: RTL
===============

Name: loop_stack

Overview:
- Loop-control unit for the BeeF core.
- Sits between instruction fetch and pc_ctrl. It watches each accepted 9-bit instruction and the current cell value, and tracks open loops on a hardware return stack.
- On a taken loop-close, it produces a redirect PC for pc_ctrl.
- On a skipped loop-open, it runs a nesting-depth forward search and drives `searching` back to fetch and alu_ctrl.

Parameters:
- PC_W, 16, program counter width.
- STACK_DEPTH, 16, number of open-loop entries; must be a power of 2.
- SEARCH_W, 8, width of the forward-search nesting counter.
- OPEN_OP, 9'h05B, instruction encoding for loop-open '['.
- CLOSE_OP, 9'h05D, instruction encoding for loop-close ']'.

Ports:
- clk, input, 1, system clock. One clock domain.
- reset, input, 1, synchronous, active-high.
- instr_valid, input, 1, instruction/pc pair is accepted this cycle. Fetch deasserts it while stalled.
- instruction, input, 9, current instruction.
- pc, input, PC_W, address of the current instruction.
- cell_zero, input, 1, current data cell == 0. Valid whenever instr_valid is high.
- jump_valid, output, 1, one-cycle redirect strobe to pc_ctrl.
- jump_pc, output, PC_W, redirect target; meaningful only while jump_valid is high.
- searching, output, 1, forward search in progress. Fetch continues sequentially; the datapath must suppress side effects.
- stack_level, output, clog2(STACK_DEPTH)+1, number of occupied stack entries.
- fault, output, 1, sticky error flag.

Behaviour:
- All outputs are registered.
- Reset values: jump_valid=0, jump_pc=0, searching=0, stack_level=0, fault=0. Search counter=0; state=RUN. Stack RAM contents are don't-care.
- Reset mid-search or mid-loop aborts everything; no pending jump survives.
- States:
  - RUN: normal execution.
  - SEARCH: skipping a loop body.
  - FAULT: error, sticky until reset.
- Each event below fires only on a cycle with instr_valid=1. Instructions other than OPEN_OP/CLOSE_OP are ignored in RUN.
- RUN, OPEN_OP, cell_zero=0:
  - Push pc; stack_level+1 on the next cycle.
  - If the stack is already full: go to FAULT and do not push.
- RUN, OPEN_OP, cell_zero=1:
  - Enter SEARCH with counter=1; no push.
  - searching=1 from the next cycle.
- RUN, CLOSE_OP, cell_zero=0:
  - Next cycle: jump_valid=1 for exactly one cycle, with jump_pc = top + 1 (the first body instruction), wrapping modulo 2^PC_W.
  - The stack is unchanged.
- RUN, CLOSE_OP, cell_zero=1:
  - Pop; stack_level-1 on the next cycle; no jump.
- RUN, CLOSE_OP, stack empty: go to FAULT regardless of cell_zero.
- SEARCH:
  - cell_zero is ignored.
  - OPEN_OP: counter+1. If the counter would exceed 2^SEARCH_W-1, go to FAULT.
  - CLOSE_OP with counter>1: counter-1.
  - CLOSE_OP with counter==1: return to RUN with counter=0; searching=0 from the next cycle.
  - The instruction after the matching ']' executes normally.
  - The stack is never touched in SEARCH.
- FAULT:
  - fault=1; searching=0; jump_valid=0.
  - All instructions are ignored until reset.
  - stack_level holds its last value.
- Latency: decision to output is 1 cycle.
- pc_ctrl must not also advance sequentially on the cycle jump_valid is high; jump_pc takes priority there.
- Back-to-back events: one event per accepted instruction. A push or pop completes in one cycle, so consecutive '[' '[' ']' each see an updated top.
- instr_valid=0 cycles hold all state. jump_valid is still a single-cycle pulse and is not extended by stalls.

Test Plan:
- Reset, then '[' at pc=0x0010 with cell_zero=0 -> stack_level=1, no jump. Then ']' at pc=0x0014 with cell_zero=0 -> next cycle jump_valid=1, jump_pc=0x0011, stack_level stays 1.
- Same loop, ']' with cell_zero=1 -> stack_level=0, jump_valid stays 0.
- '[' with cell_zero=1 at 0x0020, then stream '[' '+' ']' '-' ']' '>' -> searching high after 0x0020 and low the cycle after the second ']'. stack_level=0 throughout; '>' is processed in RUN.
- Push STACK_DEPTH=16 nested '[' with cell_zero=0 -> stack_level=16, fault=0. A 17th '[' -> fault=1 next cycle; further ']' inputs ignored; stack_level stays 16.
- ']' with an empty stack -> fault=1 next cycle. Then assert reset -> all outputs return to 0 and normal operation resumes.
- Assert reset while searching=1 with counter=3 -> searching=0 next cycle. A following ']' with an empty stack produces fault (counter not retained). Also: ']' with top=0xFFFF and cell_zero=0 -> jump_pc=0x0000.

Source files
------------

// File: rtl/loop_stack.sv
// Loop-control unit for the BeeF core: tracks open loops on a hardware return
// stack, redirects fetch on taken loop-closes, and skips bodies of untaken loops.
module loop_stack #(
    parameter int          PC_W        = 16,
    parameter int          STACK_DEPTH = 16,
    parameter int          SEARCH_W    = 8,
    parameter logic [8:0]  OPEN_OP     = 9'h05B,
    parameter logic [8:0]  CLOSE_OP    = 9'h05D
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           instr_valid,
    input  logic [8:0]                     instruction,
    input  logic [PC_W-1:0]                pc,
    input  logic                           cell_zero,
    output logic                           jump_valid,
    output logic [PC_W-1:0]                jump_pc,
    output logic                           searching,
    output logic [$clog2(STACK_DEPTH):0]   stack_level,
    output logic                           fault
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int LVL_W = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SEARCH,
        ST_FAULT
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [SEARCH_W-1:0] count;
    logic [SEARCH_W-1:0] count_next;
    logic [LVL_W-1:0]    level_next;
    logic                push;
    logic                do_jump;

    logic [PC_W-1:0]     stack_mem [STACK_DEPTH];
    logic [IDX_W-1:0]    top_idx;
    logic [PC_W-1:0]     top;

    logic is_open;
    logic is_close;
    logic full;
    logic empty;

    assign is_open  = instr_valid && (instruction == OPEN_OP);
    assign is_close = instr_valid && (instruction == CLOSE_OP);
    assign full     = (stack_level == LVL_W'(STACK_DEPTH));
    assign empty    = (stack_level == '0);
    // Low bits wrap correctly when the stack is full (level 16 -> index 15).
    assign top_idx  = stack_level[IDX_W-1:0] - IDX_W'(1);
    assign top      = stack_mem[top_idx];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            count       <= '0;
            stack_level <= '0;
            jump_valid  <= 1'b0;
            jump_pc     <= '0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            stack_level <= level_next;
            jump_valid  <= do_jump;
            if (do_jump) begin
                jump_pc <= top + PC_W'(1);
            end
        end
    end

    // NOTE: the stack RAM is deliberately not reset; stack_level alone
    // defines which entries are valid, so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[stack_level[IDX_W-1:0]] <= pc;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        level_next = stack_level;
        push       = 1'b0;
        do_jump    = 1'b0;
        case (state)
            ST_RUN: begin
                if (is_open) begin
                    if (cell_zero) begin
                        state_next = ST_SEARCH;
                        count_next = SEARCH_W'(1);
                    end else if (full) begin
                        state_next = ST_FAULT;
                    end else begin
                        push       = 1'b1;
                        level_next = stack_level + LVL_W'(1);
                    end
                end else if (is_close) begin
                    if (empty) begin
                        state_next = ST_FAULT;
                    end else if (!cell_zero) begin
                        do_jump = 1'b1;
                    end else begin
                        level_next = stack_level - LVL_W'(1);
                    end
                end
            end
            ST_SEARCH: begin
                // Nesting depth of the loop being skipped; cell_zero is irrelevant here.
                if (is_open) begin
                    if (count == '1) begin
                        state_next = ST_FAULT;
                    end else begin
                        count_next = count + SEARCH_W'(1);
                    end
                end else if (is_close) begin
                    if (count == SEARCH_W'(1)) begin
                        state_next = ST_RUN;
                        count_next = '0;
                    end else begin
                        count_next = count - SEARCH_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        searching = (state == ST_SEARCH);
        fault     = (state == ST_FAULT);
    end

endmodule
